photon_cnt_packer: RTL and testbench

Downstream stage of the periodic photon counter output. Captures each one-cycle c_cnt_ready strobe together with its count value and c_lockin_inc flag into a small FIFO. Serializes each entry into a fixed-length, checksummed byte frame on a valid/ready byte stream that feeds the host link (USB/UART bridge). Count periods stay lossless across host back-pressure up to DEPTH entries. Any loss is visible to the host through sequence-number gaps and a sticky flag.

---
 rtl/photon_cnt_packer_if.sv | 14 +
 rtl/photon_cnt_packer.sv | 146 ++++++++++++++
 tb/tb_photon_cnt_packer.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/photon_cnt_packer_if.sv
// Byte stream from the packer to the host link bridge, plus FSM state for debug.
// Handshake: a byte moves on a rising clock edge where c_byte_valid and
// c_byte_ready are both 1. Once c_byte_valid is raised it stays raised, with
// c_byte unchanged, until that transfer happens. c_byte_valid never waits on
// c_byte_ready.
interface photon_cnt_packer_if;
    logic [7:0] c_byte;
    logic       c_byte_valid;
    logic       c_byte_ready;
    logic       state_dbg;

    modport master (output c_byte, output c_byte_valid, output state_dbg, input c_byte_ready);
    modport slave  (input c_byte, input c_byte_valid, input state_dbg, output c_byte_ready);
endinterface

// File: rtl/photon_cnt_packer.sv
// Photon count packer: buffers count strobes in a FIFO and sends each entry as
// a fixed-length frame: A5 header, {inc, seq}, count bytes MSB first, XOR checksum.
module photon_cnt_packer #(
    parameter int COUNTSIZE = 32,
    parameter int DEPTH     = 16
) (
    input  logic                   c_clk,
    input  logic                   c_rst,
    input  logic                   c_cnt_ready,
    input  logic [COUNTSIZE-1:0]   c_ch1_cnt_output,
    input  logic                   c_lockin_inc,
    input  logic                   c_ovf_clr,
    photon_cnt_packer_if.master    c_bus,
    output logic                   c_overflow,
    output logic [$clog2(DEPTH):0] c_fifo_level
);
    localparam int NB = COUNTSIZE / 8;
    localparam int N  = NB + 3;
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = COUNTSIZE + 8;
    localparam int IW = $clog2(N);

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [N-1:0][7:0]     frame_q, frame_d;
    logic [EW-1:0]         mem_q [DEPTH];
    logic [EW-1:0]         mem_wr_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic [6:0]            seq_q, seq_d;
    logic                  ovf_q, ovf_d;
    logic [EW-1:0]         head;
    logic [7:0]            csum;
    logic                  push, pop;
    logic [7:0]            byte_out;
    logic                  valid_out;

    // Pop only from IDLE; a push into a full FIFO is allowed when the pop frees a slot.
    assign head     = mem_q[rd_ptr_q];
    assign pop      = (state_q == IDLE) && (level_q != '0);
    assign push     = c_cnt_ready && ((level_q != LW'(DEPTH)) || pop);
    assign mem_wr_d = {c_lockin_inc, seq_q, c_ch1_cnt_output};

    // FIFO storage; contents are don't-care until written, so no reset.
    always_ff @(posedge c_clk) begin
        if (push) mem_q[wr_ptr_q] <= mem_wr_d;
    end

    // Pointer, level, sequence and overflow bookkeeping.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q;
        if (push && !pop) level_d = level_q + LW'(1);
        else if (pop && !push) level_d = level_q - LW'(1);
        seq_d = c_cnt_ready ? seq_q + 7'd1 : seq_q;
        ovf_d = ovf_q;
        if (c_cnt_ready && !push) ovf_d = 1'b1;
        else if (c_ovf_clr) ovf_d = 1'b0;
    end

    // Frame register loaded whole at pop; checksum taken from the stored entry.
    always_comb begin
        frame_d = frame_q;
        csum    = head[EW-1 -: 8];
        if (pop) begin
            frame_d[0] = 8'hA5;
            frame_d[1] = head[EW-1 -: 8];
            for (int i = 0; i < NB; i++) begin
                frame_d[2+i] = head[COUNTSIZE-1-8*i -: 8];
                csum         = csum ^ head[COUNTSIZE-1-8*i -: 8];
            end
            frame_d[N-1] = csum;
        end
    end

    // Datapath registers.
    always_ff @(posedge c_clk or posedge c_rst) begin
        if (c_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            seq_q    <= '0;
            ovf_q    <= 1'b0;
            frame_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            seq_q    <= seq_d;
            ovf_q    <= ovf_d;
            frame_q  <= frame_d;
        end
    end

    // FSM state register.
    always_ff @(posedge c_clk or posedge c_rst) begin
        if (c_rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // FSM next state: one IDLE cycle per frame, index advances on each transfer.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    state_d = SEND;
                    idx_d   = '0;
                end
            end
            SEND: begin
                if (c_bus.c_byte_ready) begin
                    if (idx_q == IW'(N-1)) state_d = IDLE;
                    else idx_d = idx_q + IW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: depend only on registered state, never on c_byte_ready.
    always_comb begin
        valid_out = (state_q == SEND);
        byte_out  = 8'h00;
        for (int i = 0; i < N; i++) begin
            if (valid_out && (idx_q == IW'(i))) byte_out = frame_q[i];
        end
    end

    assign c_bus.c_byte       = byte_out;
    assign c_bus.c_byte_valid = valid_out;
    assign c_bus.state_dbg    = state_q;
    assign c_overflow         = ovf_q;
    assign c_fifo_level       = level_q;
endmodule

// File: tb/tb_photon_cnt_packer.sv
// Bench for photon_cnt_packer: directed vector table, hand-written corner
// sequences, and random traffic checked every cycle against a queue model.
module tb_photon_cnt_packer;
    localparam int DEPTH = 16;
    localparam int N     = 7;
    localparam int EW    = 40;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        strobe = 1'b0;
    logic [31:0] cnt = '0;
    logic        inc = 1'b0;
    logic        clr = 1'b0;
    logic        ovf;
    logic [4:0]  level;

    photon_cnt_packer_if bus();

    photon_cnt_packer #(.COUNTSIZE(32), .DEPTH(DEPTH)) dut (
        .c_clk            (clk),
        .c_rst            (rst),
        .c_cnt_ready      (strobe),
        .c_ch1_cnt_output (cnt),
        .c_lockin_inc     (inc),
        .c_ovf_clr        (clr),
        .c_bus            (bus),
        .c_overflow       (ovf),
        .c_fifo_level     (level)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame byte idx of an entry {inc, seq, count}, built from the frame rules.
    function automatic logic [7:0] frame_byte(logic [EW-1:0] e, int idx);
        logic [7:0] b [N];
        b[0] = 8'hA5;
        b[1] = e[39:32];
        for (int k = 0; k < 4; k++) b[2+k] = 8'((e[31:0] >> (24 - 8*k)) & 32'hFF);
        b[6] = b[1] ^ b[2] ^ b[3] ^ b[4] ^ b[5];
        return b[idx];
    endfunction

    // ---------------- reference model ----------------
    logic [EW-1:0] exp_q [$];
    logic          m_send  = 1'b0;
    int            m_idx   = 0;
    logic [EW-1:0] m_frame = '0;
    logic          m_ovf   = 1'b0;
    logic [6:0]    m_seq   = '0;
    logic          m_pop, m_acc;
    logic [EW-1:0] m_ent;
    logic [7:0]    rx_q [$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
            m_send = 1'b0; m_idx = 0; m_frame = '0; m_ovf = 1'b0; m_seq = '0;
        end else begin
            m_pop = !m_send && (exp_q.size() > 0);
            m_acc = strobe && ((exp_q.size() < DEPTH) || m_pop);
            m_ent = {inc, m_seq, cnt};
            if (strobe) m_seq = m_seq + 7'd1;
            if (strobe && !m_acc) m_ovf = 1'b1;
            else if (clr) m_ovf = 1'b0;
            if (m_send && bus.c_byte_ready) begin
                if (m_idx == N-1) m_send = 1'b0;
                else m_idx++;
            end
            if (m_pop) begin
                m_frame = exp_q.pop_front();
                m_send  = 1'b1;
                m_idx   = 0;
            end
            if (m_acc) exp_q.push_back(m_ent);
        end
    end

    // Per-cycle scoreboard against the model, and capture of transferred bytes.
    always @(negedge clk) begin
        if (!rst) begin
            check("valid", bus.c_byte_valid, m_send);
            if (m_send) check("byte", bus.c_byte, frame_byte(m_frame, m_idx));
            check("level", level, exp_q.size());
            check("overflow", ovf, m_ovf);
            if (bus.c_byte_valid && bus.c_byte_ready) rx_q.push_back(bus.c_byte);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(logic [31:0] c, logic i);
        strobe = 1'b1; cnt = c; inc = i;
        tick();
        strobe = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_valid", bus.c_byte_valid, 1'b0);
        check("rst_byte", bus.c_byte, 8'h00);
        check("rst_ovf", ovf, 1'b0);
        check("rst_level", level, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        rx_q.delete();
    endtask

    task automatic wait_rx(int n, int budget);
        int k = 0;
        while (rx_q.size() < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        check("rx_timeout", rx_q.size() >= n, 1'b1);
    endtask

    task automatic wait_drain(int budget);
        int k = 0;
        bus.c_byte_ready = 1'b1;
        clr = 1'b0;
        do begin
            @(negedge clk);
            k++;
        end while ((level != 0 || bus.c_byte_valid) && k < budget);
        check("drain_timeout", k < budget, 1'b1);
        tick();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [31:0] cnt;
        logic        inc;
        logic [7:0]  exp_b [N];
    } vec_t;
    vec_t vecs [4];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int gap;
        logic [31:0] c;

        vecs[0].cnt = 32'h12345678; vecs[0].inc = 1'b1;
        vecs[0].exp_b = '{8'hA5, 8'h80, 8'h12, 8'h34, 8'h56, 8'h78, 8'h88};
        vecs[1].cnt = 32'h00000000; vecs[1].inc = 1'b0;
        vecs[1].exp_b = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
        vecs[2].cnt = 32'hFFFFFFFF; vecs[2].inc = 1'b1;
        vecs[2].exp_b = '{8'hA5, 8'h82, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h82};
        vecs[3].cnt = 32'hDEADBEEF; vecs[3].inc = 1'b0;
        vecs[3].exp_b = '{8'hA5, 8'h03, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h21};

        bus.c_byte_ready = 1'b0;
        do_reset();

        // Table vectors with sink always ready; first one also checks latency.
        bus.c_byte_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rx_q.delete();
            send(vecs[i].cnt, vecs[i].inc);
            if (i == 0) begin
                @(negedge clk);
                check("lat_t1_valid", bus.c_byte_valid, 1'b0);
                @(negedge clk);
                check("lat_t2_valid", bus.c_byte_valid, 1'b1);
                check("lat_t2_byte", bus.c_byte, 8'hA5);
                repeat (6) @(negedge clk);
                check("lat_last_valid", bus.c_byte_valid, 1'b1);
                @(negedge clk);
                check("lat_end_valid", bus.c_byte_valid, 1'b0);
            end
            wait_rx(N, 40);
            for (int j = 0; j < N; j++)
                check($sformatf("vec%0d_b%0d", i, j), rx_q[j], vecs[i].exp_b[j]);
            repeat (2) tick();
        end

        // Back-pressure: ready toggles every cycle during the frame.
        rx_q.delete();
        send(32'hCAFE0155, 1'b0);
        k = 0;
        while (rx_q.size() < N && k < 60) begin
            bus.c_byte_ready = ~bus.c_byte_ready;
            tick();
            k++;
        end
        check("bp_timeout", rx_q.size() >= N, 1'b1);
        for (int j = 0; j < N; j++)
            check($sformatf("bp_b%0d", j), rx_q[j], frame_byte({1'b0, 7'd4, 32'hCAFE0155}, j));
        wait_drain(20);

        // Overflow: 18 strobes while sink blocked, seq 17 is lost.
        do_reset();
        bus.c_byte_ready = 1'b0;
        for (int i = 0; i < 18; i++) send($urandom, 1'($urandom_range(0, 1)));
        tick();
        check("ovf_set", ovf, 1'b1);
        check("ovf_level", level, 16);
        bus.c_byte_ready = 1'b1;
        wait_rx(17 * N, 17 * (N + 1) + 20);
        repeat (20) tick();
        check("ovf_frames", rx_q.size(), 17 * N);
        for (int i = 0; i < 17; i++)
            check($sformatf("ovf_seq%0d", i), rx_q[i*N+1][6:0], i);
        check("ovf_sticky", ovf, 1'b1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        @(negedge clk);
        check("ovf_cleared", ovf, 1'b0);

        // Full FIFO: strobe in the pop cycle is accepted; then set beats clear.
        do_reset();
        bus.c_byte_ready = 1'b0;
        for (int i = 0; i < 17; i++) send($urandom, 1'b1);
        tick();
        check("full_level", level, 16);
        check("full_ovf", ovf, 1'b0);
        bus.c_byte_ready = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (bus.c_byte_valid && k < 20);
        check("full_idle_timeout", k < 20, 1'b1);
        strobe = 1'b1; cnt = 32'h0F0F0F0F;
        tick();
        strobe = 1'b0;
        bus.c_byte_ready = 1'b0;
        @(negedge clk);
        check("pop_push_level", level, 16);
        check("pop_push_ovf", ovf, 1'b0);
        tick();
        strobe = 1'b1; clr = 1'b1;
        tick();
        strobe = 1'b0; clr = 1'b0;
        @(negedge clk);
        check("set_beats_clr", ovf, 1'b1);
        wait_drain(200);

        // Seq wrap: 130 strobes every 8 cycles, sink always ready.
        do_reset();
        bus.c_byte_ready = 1'b1;
        for (int i = 0; i < 130; i++) begin
            send($urandom, 1'($urandom_range(0, 1)));
            repeat (7) tick();
        end
        wait_drain(40);
        check("wrap_frames", rx_q.size(), 130 * N);
        check("wrap_ovf", ovf, 1'b0);
        for (int i = 0; i < 130; i++)
            check($sformatf("wrap_seq%0d", i), rx_q[i*N+1][6:0], i % 128);

        // Reset mid-frame after B3 has transferred.
        do_reset();
        bus.c_byte_ready = 1'b1;
        send(32'h11223344, 1'b0);
        wait_rx(4, 20);
        #2 rst = 1'b1;
        #1;
        check("midrst_valid", bus.c_byte_valid, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        rx_q.delete();
        repeat (5) tick();
        check("midrst_no_residue", rx_q.size(), 0);
        send(32'h0BADF00D, 1'b1);
        wait_rx(N, 40);
        for (int j = 0; j < N; j++)
            check($sformatf("midrst_b%0d", j), rx_q[j], frame_byte({1'b1, 7'd0, 32'h0BADF00D}, j));

        // Random traffic with random back-pressure and clears.
        do_reset();
        gap = 0;
        for (int i = 0; i < 1500; i++) begin
            bus.c_byte_ready = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 40) == 0);
            if (gap == 0) begin
                c = $urandom;
                strobe = 1'b1; cnt = c; inc = 1'($urandom_range(0, 1));
                gap = $urandom_range(0, 12);
            end else begin
                strobe = 1'b0;
                gap--;
            end
            tick();
        end
        strobe = 1'b0;
        wait_drain(400);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
